// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle ARM64 control path:
// FSM states, opcode match values, instruction-class encoding and
// the ALUOp / pc_src / fault codes driven by the controller.
package cpu_pkg;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    // Opcode field ranges (all fields end at bit 31)
    localparam int OPC_MSB    = 31;
    localparam int OPC9_LSB   = 23;   // MOVZ, SUBI
    localparam int OPC8_LSB   = 24;   // CMP, CBZ
    localparam int OPC11_LSB  = 21;   // LDUR, STUR
    localparam int OPC6_LSB   = 26;   // B

    // Opcode match values
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;
    localparam logic [8:0]  OP_SUBI = 9'b110100010;
    localparam logic [7:0]  OP_CMP  = 8'b11101011;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    // One-hot instruction class bit positions
    localparam int CLS_MOVZ    = 0;
    localparam int CLS_SUBI    = 1;
    localparam int CLS_CMP     = 2;
    localparam int CLS_LDUR    = 3;
    localparam int CLS_STUR    = 4;
    localparam int CLS_CBZ     = 5;
    localparam int CLS_B       = 6;
    localparam int CLS_ILLEGAL = 7;
    localparam int CLS_W       = 8;
    typedef logic [CLS_W-1:0] cls_t;

    // ALUOp codes consumed by alu_control
    localparam logic [1:0] ALUOP_ADDR   = 2'b00;
    localparam logic [1:0] ALUOP_CBZ    = 2'b01;
    localparam logic [1:0] ALUOP_DECODE = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;

    // Sticky fault codes
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Single shared memory port: the controller requests, memory acknowledges.
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/multicycle_control_opcode_classify.sv
// Combinational opcode classifier: instruction word -> one-hot class.
// Exactly one bit of o_cls is set; unmatched encodings map to ILLEGAL.
module opcode_classify
    import cpu_pkg::*;
(
    input  logic [31:0] i_instruction,
    output cls_t        o_cls
);

    // Low bits carry operands only; they never affect the class.
    logic w_unused_bits;
    assign w_unused_bits = ^i_instruction[OPC11_LSB-1:0];

    // Match the opcode fields in priority order (encodings do not overlap)
    always_comb begin
        o_cls = '0;
        if (i_instruction[OPC_MSB:OPC9_LSB] == OP_MOVZ) begin
            o_cls[CLS_MOVZ] = 1'b1;
        end else if (i_instruction[OPC_MSB:OPC9_LSB] == OP_SUBI) begin
            o_cls[CLS_SUBI] = 1'b1;
        end else if (i_instruction[OPC_MSB:OPC8_LSB] == OP_CMP) begin
            o_cls[CLS_CMP] = 1'b1;
        end else if (i_instruction[OPC_MSB:OPC11_LSB] == OP_LDUR) begin
            o_cls[CLS_LDUR] = 1'b1;
        end else if (i_instruction[OPC_MSB:OPC11_LSB] == OP_STUR) begin
            o_cls[CLS_STUR] = 1'b1;
        end else if (i_instruction[OPC_MSB:OPC8_LSB] == OP_CBZ) begin
            o_cls[CLS_CBZ] = 1'b1;
        end else if (i_instruction[OPC_MSB:OPC6_LSB] == OP_B) begin
            o_cls[CLS_B] = 1'b1;
        end else begin
            o_cls[CLS_ILLEGAL] = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle ARM64 core. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB/BRANCH, arbitrates the single memory
// port, and traps illegal opcodes and memory timeouts into a sticky FAULT.
// Outputs decode from the state register (plus mem_ack for ir_write and
// zero for pc_write in BRANCH) so an async reset clears them immediately.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 200,
    parameter int TO_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [31:0]          instruction,
    input  logic                 zero,
    multicycle_control_if.master mem_if,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic [1:0]           ALUOp,
    output logic                 ALUread,
    output logic                 alu_src,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 flags_write,
    output logic [1:0]           fault
);

    // Counter value at which an unanswered request has waited MEM_TIMEOUT cycles
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_SAT  = '1;

    state_t          r_state;
    state_t          w_next_state;
    state_t          w_boundary;
    cls_t            w_cls;
    cls_t            r_cls;
    logic [TO_W-1:0] r_cnt;
    logic [1:0]      r_fault;
    logic [1:0]      w_fault_next;
    logic            w_mem_phase;
    logic            w_ack;
    logic            w_timeout;
    logic            w_unused_cls;

    opcode_classify u_classify (
        .i_instruction (instruction),
        .o_cls         (w_cls)
    );

    // ILLEGAL never reaches the latched class (DECODE traps it first)
    assign w_unused_cls = r_cls[CLS_ILLEGAL];

    // mem_ack only counts while the port is actually requested
    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_ack       = w_mem_phase & mem_if.mem_ack;
    assign w_timeout   = w_mem_phase & ~mem_if.mem_ack & (r_cnt >= TO_LAST);
    // Every instruction boundary re-samples run
    assign w_boundary  = run ? S_FETCH : S_IDLE;

    // Next-state and fault-code selection
    always_comb begin
        w_next_state = r_state;
        w_fault_next = r_fault;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_FETCH: begin
                if (w_ack) begin
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_FAULT;
                    w_fault_next = FAULT_TIMEOUT;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                if (w_cls[CLS_MOVZ] | w_cls[CLS_SUBI] | w_cls[CLS_CMP] |
                    w_cls[CLS_LDUR] | w_cls[CLS_STUR]) begin
                    w_next_state = S_EXEC;
                end else if (w_cls[CLS_CBZ] | w_cls[CLS_B]) begin
                    w_next_state = S_BRANCH;
                end else begin
                    w_next_state = S_FAULT;
                    w_fault_next = FAULT_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (r_cls[CLS_MOVZ] | r_cls[CLS_SUBI]) begin
                    w_next_state = S_WB;
                end else if (r_cls[CLS_CMP]) begin
                    w_next_state = w_boundary;
                end else if (r_cls[CLS_LDUR] | r_cls[CLS_STUR]) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_FAULT;
                    w_fault_next = FAULT_ILLEGAL;
                end
            end
            S_MEM: begin
                if (w_ack) begin
                    if (r_cls[CLS_LDUR]) begin
                        w_next_state = S_WB;
                    end else begin
                        w_next_state = w_boundary;
                    end
                end else if (w_timeout) begin
                    w_next_state = S_FAULT;
                    w_fault_next = FAULT_TIMEOUT;
                end else begin
                    w_next_state = S_MEM;
                end
            end
            S_WB:     w_next_state = w_boundary;
            S_BRANCH: w_next_state = w_boundary;
            S_FAULT:  w_next_state = S_FAULT;
            default: begin
                w_next_state = S_FAULT;
                w_fault_next = FAULT_ILLEGAL;
            end
        endcase
    end

    // State and sticky fault registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_fault <= FAULT_NONE;
        end else begin
            r_state <= w_next_state;
            r_fault <= w_fault_next;
        end
    end

    // Latch the instruction class in DECODE for use by later states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cls <= '0;
        end else if (r_state == S_DECODE) begin
            r_cls <= w_cls;
        end else begin
            r_cls <= r_cls;
        end
    end

    // Memory wait counter: cleared on ack or on entering FETCH/MEM, else counts requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_ack || (!w_mem_phase &&
                     ((w_next_state == S_FETCH) || (w_next_state == S_MEM)))) begin
            r_cnt <= '0;
        end else if (w_mem_phase && (r_cnt != TO_SAT)) begin
            r_cnt <= r_cnt + TO_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Output decode from the current state
    always_comb begin
        mem_if.mem_req = 1'b0;
        mem_if.mem_we  = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_src         = PCSRC_PLUS4;
        ALUOp          = ALUOP_ADDR;
        ALUread        = 1'b0;
        alu_src        = 1'b0;
        reg_write      = 1'b0;
        mem_to_reg     = 1'b0;
        flags_write    = 1'b0;
        fault          = r_fault;
        case (r_state)
            S_FETCH: begin
                mem_if.mem_req = 1'b1;
                ir_write       = mem_if.mem_ack;
            end
            S_DECODE: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_PLUS4;
            end
            S_EXEC: begin
                ALUread = 1'b1;
                if (r_cls[CLS_MOVZ] | r_cls[CLS_SUBI]) begin
                    ALUOp   = ALUOP_DECODE;
                    alu_src = 1'b1;
                end else if (r_cls[CLS_CMP]) begin
                    ALUOp       = ALUOP_DECODE;
                    flags_write = 1'b1;
                end else begin
                    ALUOp   = ALUOP_ADDR;
                    alu_src = 1'b1;
                end
            end
            S_MEM: begin
                mem_if.mem_req = 1'b1;
                mem_if.mem_we  = r_cls[CLS_STUR];
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = r_cls[CLS_LDUR];
            end
            S_BRANCH: begin
                ALUOp   = ALUOP_CBZ;
                ALUread = 1'b1;
                pc_src  = PCSRC_BRANCH;
                if (r_cls[CLS_CBZ]) begin
                    pc_write = zero;
                end else if (r_cls[CLS_B]) begin
                    pc_write = 1'b1;
                end else begin
                    pc_write = 1'b0;
                end
            end
            default: begin
                fault = r_fault;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Expected behaviour is generated as a
// per-cycle trace of {inputs, expected outputs} from the instruction
// class and chosen memory latencies, then replayed against the DUT.
module tb_multicycle_control;

    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] instruction;
    logic        zero;
    logic        ir_write, pc_write, ALUread, alu_src, reg_write, mem_to_reg, flags_write;
    logic [1:0]  pc_src, ALUOp, fault;
    logic [14:0] act;

    int errors = 0;
    int checks = 0;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .instruction (instruction),
        .zero        (zero),
        .mem_if      (bus),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .ALUOp       (ALUOp),
        .ALUread     (ALUread),
        .alu_src     (alu_src),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .flags_write (flags_write),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    assign act = {bus.mem_req, bus.mem_we, ir_write, pc_write, pc_src, ALUOp,
                  ALUread, alu_src, reg_write, mem_to_reg, flags_write, fault};

    // Instruction kinds as the bench sees them (mask/value pairs)
    localparam int K_MOVZ = 0, K_SUBI = 1, K_CMP = 2, K_LDUR = 3, K_STUR = 4,
                   K_CBZ = 5, K_B = 6, K_ILL = 7;
    localparam logic [31:0] KMASK [7] = '{32'hFF800000, 32'hFF800000, 32'hFF000000,
                                          32'hFFE00000, 32'hFFE00000, 32'hFF000000,
                                          32'hFC000000};
    localparam logic [31:0] KVAL  [7] = '{32'hD2800000, 32'hD1000000, 32'hEB000000,
                                          32'hF8400000, 32'hF8000000, 32'hB4000000,
                                          32'h14000000};

    typedef struct {
        logic [31:0] ir;
        logic        run;
        logic        ack;
        logic        zero;
        logic [14:0] exp;
    } cyc_t;

    cyc_t q[$];
    cyc_t tbl[6];

    function automatic int kind_of(input logic [31:0] ir);
        for (int k = 0; k < 7; k++) begin
            if ((ir & KMASK[k]) == KVAL[k]) return k;
        end
        return K_ILL;
    endfunction

    function automatic logic [14:0] ov(input logic req, input logic we, input logic irw,
                                       input logic pcw, input logic [1:0] pcs,
                                       input logic [1:0] aop, input logic ard,
                                       input logic asrc, input logic rw, input logic m2r,
                                       input logic fw, input logic [1:0] f);
        return {req, we, irw, pcw, pcs, aop, ard, asrc, rw, m2r, fw, f};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic push(input logic [31:0] ir, input logic r, input logic a,
                        input logic z, input logic [14:0] e);
        cyc_t c;
        c.ir = ir; c.run = r; c.ack = a; c.zero = z; c.exp = e;
        q.push_back(c);
    endtask

    task automatic check(input string name, input logic [14:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: outputs got %b expected %b", name, act, e);
        end
    endtask

    // Replay the queued trace: drive on the falling edge, compare 1 ns later
    task automatic run_queue(input string name);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            instruction = q[i].ir;
            run         = q[i].run;
            bus.mem_ack = q[i].ack;
            zero        = q[i].zero;
            #1;
            check($sformatf("%s[%0d]", name, i), q[i].exp);
        end
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; bus.mem_ack = 1'b0; zero = 1'b0; instruction = 32'h0;
        #1;
        check("reset", 15'd0);
        @(negedge clk);
        #1;
        check("reset_hold", 15'd0);
        rst_n = 1'b1;
    endtask

    // IDLE cycle with run raised: outputs all zero, next cycle is FETCH
    task automatic push_start();
        push(32'h0, 1'b1, rb(), rb(), 15'd0);
    endtask

    // Expected trace of one instruction from its first FETCH cycle.
    // lf/lm: wait cycles before ack in FETCH/MEM; z: zero flag in BRANCH.
    task automatic gen_instr(input logic [31:0] ir, input int lf, input int lm,
                             input logic z, input logic run_after);
        int  k;
        logic st;
        k  = kind_of(ir);
        st = (k == K_STUR);
        for (int i = 0; i < lf; i++)
            push(ir, rb(), 1'b0, rb(), ov(1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00));
        push(ir, rb(), 1'b1, rb(), ov(1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00));
        push(ir, rb(), rb(), rb(), ov(1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00));
        case (k)
            K_MOVZ, K_SUBI: begin
                push(ir, rb(), rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00));
                push(ir, rb(), rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00));
            end
            K_CMP: begin
                push(ir, rb(), rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,1'b0,1'b0,1'b0,1'b1,2'b00));
            end
            K_LDUR, K_STUR: begin
                push(ir, rb(), rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00));
                for (int i = 0; i < lm; i++)
                    push(ir, rb(), 1'b0, rb(), ov(1'b1,st,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00));
                push(ir, rb(), 1'b1, rb(), ov(1'b1,st,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00));
                if (!st)
                    push(ir, rb(), rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00));
            end
            K_CBZ, K_B: begin
                push(ir, rb(), rb(), z, ov(1'b0,1'b0,1'b0,(k == K_CBZ) ? z : 1'b1,2'b01,2'b01,
                                           1'b1,1'b0,1'b0,1'b0,1'b0,2'b00));
            end
            default: begin
                for (int i = 0; i < 20; i++)
                    push(ir, rb(), rb(), rb(), ov(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01));
                return;
            end
        endcase
        q[q.size()-1].run = run_after;
        if (!run_after) begin
            for (int i = 0; i < int'($urandom_range(3, 1)); i++)
                push(ir, 1'b0, rb(), rb(), 15'd0);
            push_start();
        end
    endtask

    initial begin
        logic [31:0] ir;
        int          k;
        rst_n = 1'b0; run = 1'b0; bus.mem_ack = 1'b0; zero = 1'b0; instruction = 32'h0;

        // MOVZ X0,#42 with mem_ack tied high: IDLE, FETCH, DECODE, EXEC, WB, FETCH
        tbl[0] = '{32'hD2800540, 1'b1, 1'b1, 1'b0, 15'd0};
        tbl[1] = '{32'hD2800540, 1'b1, 1'b1, 1'b0,
                   ov(1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00)};
        tbl[2] = '{32'hD2800540, 1'b1, 1'b1, 1'b0,
                   ov(1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00)};
        tbl[3] = '{32'hD2800540, 1'b1, 1'b1, 1'b0,
                   ov(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00)};
        tbl[4] = '{32'hD2800540, 1'b1, 1'b1, 1'b0,
                   ov(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00)};
        tbl[5] = '{32'hD2800540, 1'b1, 1'b1, 1'b0,
                   ov(1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00)};
        do_reset();
        for (int i = 0; i < 6; i++) q.push_back(tbl[i]);
        run_queue("movz_tbl");

        // LDUR with 3-cycle MEM wait, CBZ taken/not taken, STUR, CMP,
        // and a fetch acked on exactly the last cycle before timeout
        do_reset();
        push_start();
        gen_instr(32'hF8408041, 0, 3, 1'b0, 1'b1);
        gen_instr(32'hB4000040, 0, 0, 1'b1, 1'b1);
        gen_instr(32'hB4000040, 0, 0, 1'b0, 1'b1);
        gen_instr(32'hF8000041, 2, 1, 1'b0, 1'b1);
        gen_instr(32'hEB01001F, 1, 0, 1'b0, 1'b1);
        gen_instr(32'h14000004, TIMEOUT - 1, 0, 1'b0, 1'b0);
        run_queue("directed");

        // Illegal opcode: sticky fault 01, then reset clears it
        do_reset();
        push_start();
        gen_instr(32'h00000000, 0, 0, 1'b0, 1'b1);
        run_queue("illegal");
        do_reset();
        push_start();
        gen_instr(32'hD1000421, 0, 0, 1'b0, 1'b1);
        run_queue("after_illegal");

        // Fetch never acked: 200 request cycles, then fault 10 with mem_req low
        do_reset();
        push_start();
        for (int i = 0; i < TIMEOUT; i++)
            push(32'hD2800540, 1'b1, 1'b0, rb(),
                 ov(1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00));
        for (int i = 0; i < 10; i++)
            push(32'hD2800540, 1'b1, rb(), rb(),
                 ov(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10));
        run_queue("timeout");

        // Async reset in the middle of a STUR memory wait
        do_reset();
        push_start();
        gen_instr(32'hF8000041, 0, 5, 1'b0, 1'b1);
        while (q.size() > 5) q.delete(q.size() - 1);
        run_queue("stur_pre");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem", 15'd0);
        @(negedge clk);
        #1;
        check("rst_mid_mem_hold", 15'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h0, 1'b0, 1'b1, rb(), 15'd0);
        run_queue("idle_after_rst");

        // Random instruction stream with random latencies and run drops
        do_reset();
        push_start();
        for (int n = 0; n < 60; n++) begin
            k  = int'($urandom_range(6, 0));
            ir = KVAL[k] | ($urandom & ~KMASK[k]);
            gen_instr(ir, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), rb(),
                      ($urandom_range(3, 0) != 0));
        end
        run_queue("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle ARM64 core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALUOp/ALUread interface consumed by alu_control, plus register-file, PC, IR and memory-port enables.
- Shares the single memory port between instruction fetch and LDUR/STUR data access; detects memory timeouts and illegal opcodes.

Parameters:
- MEM_TIMEOUT, 200: max cycles mem_req may stay asserted without mem_ack before FAULT.
- TO_W, 8: width of the wait counter; must satisfy MEM_TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  leave IDLE and start fetching when high.
- instruction  in  32  IR contents (datapath latches it on ir_write).
- zero  in  1  ALU zero flag, valid during BRANCH.
- mem_ack  in  1  memory port completion; sampled only while mem_req=1.
- mem_req  out  1  memory port request.
- mem_we  out  1  1 = write (STUR), 0 = read.
- ir_write  out  1  latch fetched word into IR.
- pc_write  out  1  update PC.
- pc_src  out  2  00 = PC+4, 01 = branch target.
- ALUOp  out  2  00 = address add, 01 = CBZ compare, 10 = decode by instruction.
- ALUread  out  1  ALU result valid/consumed this cycle.
- alu_src  out  1  0 = register operand, 1 = immediate.
- reg_write  out  1  write Xd.
- mem_to_reg  out  1  writeback source is memory data.
- flags_write  out  1  update NZCV (CMP).
- fault  out  2  00 none, 01 illegal opcode, 10 memory timeout; sticky.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, BRANCH, FAULT.
- Reset: state=IDLE, wait counter=0, fault=00, every output 0.
- Moore outputs decode from state only. Exceptions: ir_write = (FETCH & mem_ack); pc_write in BRANCH = taken.
- IDLE: all outputs 0. run=1 -> FETCH.
- FETCH: mem_req=1, mem_we=0. On mem_ack: ir_write=1 and -> DECODE. Zero-wait ack (ack in the first FETCH cycle) is legal.
- DECODE: pc_write=1, pc_src=00. Classify instruction:
  - MOVZ [31:23]=110100101, SUBI [31:23]=110100010, CMP [31:24]=11101011, LDUR [31:21]=11111000010, STUR [31:21]=11111000000 -> EXEC.
  - CBZ [31:24]=10110100, B [31:26]=000101 -> BRANCH.
  - Anything else -> FAULT with fault=01; PC is still written.
- EXEC, MOVZ/SUBI: ALUOp=10, alu_src=1, ALUread=1 -> WB.
- EXEC, CMP: ALUOp=10, alu_src=0, ALUread=1, flags_write=1 -> FETCH (no WB).
- EXEC, LDUR/STUR: ALUOp=00, alu_src=1, ALUread=1 -> MEM.
- MEM: mem_req=1, mem_we=1 for STUR. On ack: LDUR -> WB, STUR -> FETCH.
- WB: reg_write=1, mem_to_reg=1 only for LDUR. Then -> FETCH, or -> IDLE if run=0.
- BRANCH: ALUOp=01, ALUread=1, pc_src=01.
  - CBZ: pc_write=zero.
  - B: pc_write=1 unconditionally.
  - Then -> FETCH.
- run=0 is sampled only at instruction boundaries (every transition that would enter FETCH); such transitions enter IDLE instead. An instruction in flight always completes.
- Wait counter:
  - Cleared on entry to FETCH/MEM and on ack; increments each cycle mem_req=1 without ack, saturating.
  - Reaching MEM_TIMEOUT with no ack -> FAULT, fault=10, mem_req drops next cycle.
  - Ack in the same cycle the counter reaches MEM_TIMEOUT: the ack wins.
- FAULT: all outputs 0 except fault; exits only via rst_n.
- mem_ack while mem_req=0 is ignored.
- rst_n asserted mid-transaction: immediate async return to IDLE; mem_req deasserts without waiting for ack.
- Cycle counts with zero-wait memory (FETCH through last state):
  - B/CBZ: 3.
  - CMP: 3.
  - STUR: 4.
  - MOVZ/SUBI: 4.
  - LDUR: 5.

Decomposition:
- cpu_pkg holds:
  - state enum;
  - opcode match values and field ranges per instruction class;
  - ALUOp codes (00/01/10);
  - pc_src codes;
  - fault codes.
- One combinational sub-module, opcode_classify: instruction -> one-hot class {MOVZ, SUBI, CMP, LDUR, STUR, CBZ, B, ILLEGAL}. It is reused later by hazard logic. The FSM lives in multicycle_control.

Test Plan:
- Reset, run=1, mem_ack tied 1, IR=0xD2800540 (MOVZ X0,#42) -> FETCH, DECODE, EXEC (ALUOp=10, alu_src=1), WB (reg_write=1); exactly 4 cycles; back to FETCH.
- LDUR 0xF8408041 with mem_ack delayed 3 cycles in MEM -> mem_req held 4 cycles, then WB with mem_to_reg=1; 8 cycles total.
- CBZ 0xB4000040: zero=1 -> pc_write=1, pc_src=01 in BRANCH. Zero=0 -> pc_write=0 in BRANCH; only the DECODE PC+4 write occurs.
- IR=0x00000000 -> DECODE then FAULT, fault=01; all outputs 0 thereafter, held 20 cycles; rst_n low clears to IDLE.
- mem_ack never asserted in FETCH -> after 200 cycles enter FAULT, fault=10, mem_req=0.
- rst_n pulsed low mid-MEM of STUR -> mem_req, mem_we and all outputs 0 in the same cycle, before any clock edge; state IDLE.
